// File: rtl/pool_max.sv
// Streaming 2x2 / stride-2 signed max-pool with valid/ready on both sides.
// Horizontal pair maxima of even rows are parked in a half-row line buffer.
module pool_max #(
    parameter int NUM_WIDTH = 16,
    parameter int ROW_MAX   = 64,
    parameter int ROW_WIDTH = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 bypass,
    input  logic [ROW_WIDTH-1:0] cfg_row_len,
    input  logic [NUM_WIDTH-1:0] up_data,
    input  logic                 up_valid,
    output logic                 up_ready,
    output logic [NUM_WIDTH-1:0] dn_data,
    output logic                 dn_valid,
    input  logic                 dn_ready
);

    localparam int ADDR_W = (ROW_MAX > 2) ? $clog2(ROW_MAX / 2) : 1;

    typedef logic signed [NUM_WIDTH-1:0] pix_t;

    function automatic pix_t smax(input pix_t a, input pix_t b);
        return (a > b) ? a : b;
    endfunction

    // Odd lengths round down; zero or oversize lengths fall back to the maximum row.
    function automatic logic [ROW_WIDTH-1:0] decode_len(input logic [ROW_WIDTH-1:0] raw);
        logic [ROW_WIDTH-1:0] even;
        even = raw & {{(ROW_WIDTH-1){1'b1}}, 1'b0};
        if ((even == {ROW_WIDTH{1'b0}}) || (even > ROW_WIDTH'(ROW_MAX))) begin
            return ROW_WIDTH'(ROW_MAX);
        end else begin
            return even;
        end
    endfunction

    logic [ROW_WIDTH-1:0] col_r;
    logic                 row_odd_r;
    logic                 bypass_r;
    logic [ROW_WIDTH-1:0] row_len_r;
    pix_t                 hreg_r;
    pix_t                 dn_data_r;
    logic                 dn_valid_r;
    pix_t                 linebuf_r [ROW_MAX/2];

    logic                 idle_s;
    logic                 bypass_s;
    logic [ROW_WIDTH-1:0] row_len_s;
    logic                 accept_s;
    logic [ADDR_W-1:0]    lb_addr_s;
    pix_t                 lb_rdata_s;
    pix_t                 hmax_s;
    logic [ROW_WIDTH-1:0] col_nxt_s;
    logic                 row_odd_nxt_s;
    logic                 hreg_we_s;
    logic                 lb_we_s;
    logic                 load_s;
    pix_t                 dn_data_nxt_s;
    logic                 dn_valid_nxt_s;

    // While idle the live config is what gets latched, so the first pixel of a row pair already obeys it.
    assign idle_s     = (col_r == {ROW_WIDTH{1'b0}}) && !row_odd_r;
    assign bypass_s   = idle_s ? bypass : bypass_r;
    assign row_len_s  = idle_s ? decode_len(cfg_row_len) : row_len_r;

    assign up_ready   = !dn_valid_r || dn_ready;
    assign accept_s   = up_valid && up_ready;
    assign lb_addr_s  = col_r[ADDR_W:1];
    assign lb_rdata_s = linebuf_r[lb_addr_s];
    assign hmax_s     = smax(hreg_r, up_data);
    assign dn_data    = dn_data_r;
    assign dn_valid   = dn_valid_r;

    // Next-state for the position counters, pair register, line buffer write and output register.
    always_comb begin
        col_nxt_s     = col_r;
        row_odd_nxt_s = row_odd_r;
        hreg_we_s     = 1'b0;
        lb_we_s       = 1'b0;
        load_s        = 1'b0;
        dn_data_nxt_s = dn_data_r;
        if (accept_s) begin
            if (col_r == (row_len_s - ROW_WIDTH'(1))) begin
                col_nxt_s     = {ROW_WIDTH{1'b0}};
                row_odd_nxt_s = !row_odd_r;
            end else begin
                col_nxt_s     = col_r + ROW_WIDTH'(1);
            end
            if (bypass_s) begin
                load_s        = 1'b1;
                dn_data_nxt_s = up_data;
            end else if (!col_r[0]) begin
                hreg_we_s     = 1'b1;
            end else if (!row_odd_r) begin
                lb_we_s       = 1'b1;
            end else begin
                load_s        = 1'b1;
                dn_data_nxt_s = smax(hmax_s, lb_rdata_s);
            end
        end else begin
            col_nxt_s     = col_r;
        end
        if (load_s) begin
            dn_valid_nxt_s = 1'b1;
        end else begin
            dn_valid_nxt_s = dn_valid_r && !dn_ready;
        end
    end

    // Control, config latch and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_r      <= {ROW_WIDTH{1'b0}};
            row_odd_r  <= 1'b0;
            bypass_r   <= 1'b0;
            row_len_r  <= ROW_WIDTH'(ROW_MAX);
            hreg_r     <= {NUM_WIDTH{1'b0}};
            dn_data_r  <= {NUM_WIDTH{1'b0}};
            dn_valid_r <= 1'b0;
        end else begin
            col_r      <= col_nxt_s;
            row_odd_r  <= row_odd_nxt_s;
            dn_data_r  <= dn_data_nxt_s;
            dn_valid_r <= dn_valid_nxt_s;
            if (idle_s) begin
                bypass_r  <= bypass;
                row_len_r <= decode_len(cfg_row_len);
            end
            if (hreg_we_s) begin
                hreg_r <= up_data;
            end
        end
    end

    // Line buffer storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (rst_n && lb_we_s) begin
            linebuf_r[lb_addr_s] <= hmax_s;
        end
    end

endmodule
